// File: rtl/riscv_pkg.sv
// Shared load/store encodings and clear-sequencer states for the M-stage data memory.
// No logic; type and constant definitions only.
// No flow control; consumed by data_mem_resp and mem_lane_align.
package riscv_pkg;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables/replicated data, load lane select/extension, access legality.
// Purely combinational, zero latency.
// No backpressure; caller gates enables with err.
module mem_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  RW_type,
    input  logic [1:0]  offset,
    input  logic        store,
    input  logic [31:0] Wr_mem_data,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_aligned,
    output logic [31:0] rdata,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword[8*offset +: 8];
    assign half_sel = offset[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        byte_en       = 4'b0000;
        wdata_aligned = 32'h0;
        rdata         = 32'h0;
        err           = 1'b0;
        case (RW_type)
            RW_B: begin
                byte_en       = 4'b0001 << offset;
                wdata_aligned = {4{Wr_mem_data[7:0]}};
                rdata         = {{24{byte_sel[7]}}, byte_sel};
            end
            RW_BU: begin
                err   = store;
                rdata = {24'h0, byte_sel};
            end
            RW_H: begin
                err           = offset[0];
                byte_en       = offset[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{Wr_mem_data[15:0]}};
                rdata         = {{16{half_sel[15]}}, half_sel};
            end
            RW_HU: begin
                err   = offset[0] | store;
                rdata = {16'h0, half_sel};
            end
            RW_W: begin
                err           = (offset != 2'b00);
                byte_en       = 4'b1111;
                wdata_aligned = Wr_mem_data;
                rdata         = rword;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: byte-enabled stores, extended loads, sticky access-error capture, post-reset clear.
// Loads are combinational (0 cycles); stores commit on the rising edge.
// Only backpressure is busy during the clear sequence; requests then are dropped.
module data_mem_resp
    import riscv_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        W_en,
    input  logic        R_en,
    input  logic [31:0] ram_addr,
    input  logic [2:0]  RW_type,
    input  logic [31:0] Wr_mem_data,
    output logic [31:0] Rd_mem_data,
    output logic        busy,
    output logic        acc_err,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    localparam int AW = $clog2(DEPTH);

    clr_state_t     state;
    logic [AW-1:0]  clr_cnt;
    logic [AW-1:0]  word_idx;
    logic [31:0]    rword;
    logic [31:0]    rdata;
    logic [31:0]    wdata_aligned;
    logic [3:0]     byte_en;
    logic           err;
    logic           req;
    logic           we;
    logic           clear_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == AW'(DEPTH - 1))
                state <= IDLE;
        end
    end

    assign busy     = (state == CLEAR);
    assign word_idx = ram_addr[AW+1:2];
    assign req      = (W_en | R_en) & ~busy;
    assign we       = W_en & ~busy & ~err;
    assign clear_we = busy & ~rst;

    mem_lane_align u_align (
        .RW_type      (RW_type),
        .offset       (ram_addr[1:0]),
        .store        (W_en),
        .Wr_mem_data  (Wr_mem_data),
        .rword        (rword),
        .byte_en      (byte_en),
        .wdata_aligned(wdata_aligned),
        .rdata        (rdata),
        .err          (err)
    );

    // One byte-wide bank per lane; the read is taken before any same-cycle write lands.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0] ram [DEPTH];

        always_ff @(posedge clk) begin
            if (clear_we)
                ram[clr_cnt] <= 8'h00;
            else if (we && byte_en[b])
                ram[word_idx] <= wdata_aligned[8*b +: 8];
        end

        assign rword[8*b +: 8] = ram[word_idx];
    end

    assign Rd_mem_data = (R_en && !busy && !err) ? rdata : 32'h0;

    // A new error outranks err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_err  <= 1'b0;
            err_addr <= 32'h0;
        end else if (req && err) begin
            acc_err  <= 1'b1;
            err_addr <= ram_addr;
        end else if (err_clr) begin
            acc_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        W_en, R_en, err_clr;
    logic [31:0] ram_addr, Wr_mem_data, Rd_mem_data, err_addr;
    logic [2:0]  RW_type;
    logic        busy, acc_err;

    int errors = 0;
    int checks = 0;

    data_mem_resp #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .W_en       (W_en),
        .R_en       (R_en),
        .ram_addr   (ram_addr),
        .RW_type    (RW_type),
        .Wr_mem_data(Wr_mem_data),
        .Rd_mem_data(Rd_mem_data),
        .busy       (busy),
        .acc_err    (acc_err),
        .err_addr   (err_addr),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: word array plus error registers, from the access rules.
    logic [31:0] m_mem [DEPTH];
    logic        m_acc;
    logic [31:0] m_ea;

    function automatic logic m_err(input logic [2:0] t, input logic [1:0] off, input logic st);
        if (t == 3'd3 || t == 3'd6 || t == 3'd7) return 1'b1;
        if (st && (t == 3'd4 || t == 3'd5)) return 1'b1;
        if ((t == 3'd1 || t == 3'd5) && off[0]) return 1'b1;
        if (t == 3'd2 && off != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] w, input logic [2:0] t, input logic [1:0] off);
        logic [31:0] bsh, hsh;
        bsh = w >> (8 * off);
        hsh = w >> (16 * off[1]);
        case (t)
            3'd0: return {{24{bsh[7]}}, bsh[7:0]};
            3'd4: return {24'h0, bsh[7:0]};
            3'd1: return {{16{hsh[15]}}, hsh[15:0]};
            3'd5: return {16'h0, hsh[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_acc = 1'b0;
        m_ea  = 32'h0;
    endtask

    task automatic model_step(input logic w, input logic r, input logic [31:0] a, input logic [2:0] t,
                              input logic [31:0] d, input logic c, output logic [31:0] exp_rd);
        int          idx;
        logic        e;
        logic [31:0] mask;
        int          sh;
        idx    = int'(a[5:2]);
        e      = (w | r) && m_err(t, a[1:0], w);
        exp_rd = (r && !e) ? m_read(m_mem[idx], t, a[1:0]) : 32'h0;
        if (w && !e) begin
            sh   = (t == 3'd0) ? 8 * int'(a[1:0]) : (t == 3'd1) ? 16 * int'(a[1]) : 0;
            mask = (t == 3'd0) ? (32'hFF << sh) : (t == 3'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
            m_mem[idx] = (m_mem[idx] & ~mask) | ((d << sh) & mask);
        end
        if (e) begin
            m_acc = 1'b1;
            m_ea  = a;
        end else if (c) begin
            m_acc = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle of access: read data sampled mid-cycle, registers sampled after the edge.
    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] d, input logic c,
                          output logic [31:0] rd, output logic ae, output logic [31:0] ea,
                          output logic [31:0] exp_rd);
        @(negedge clk);
        W_en = w; R_en = r; ram_addr = a; RW_type = t; Wr_mem_data = d; err_clr = c;
        #1 rd = Rd_mem_data;
        model_step(w, r, a, t, d, c, exp_rd);
        @(posedge clk);
        #1 ae = acc_err;
        ea = err_addr;
    endtask

    task automatic idle_inputs();
        W_en = 0; R_en = 0; ram_addr = 0; RW_type = 0; Wr_mem_data = 0; err_clr = 0;
    endtask

    task automatic count_busy(output int n, output int rd_bad);
        n = 0;
        rd_bad = 0;
        while (busy === 1'b1 && n < 100) begin
            if (Rd_mem_data !== 32'h0) rd_bad++;
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        w, r;
        logic [31:0] a;
        logic [2:0]  t;
        logic [31:0] d;
        logic        c;
        logic [31:0] rd;
        logic        ae;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl [22];

    initial begin
        logic [31:0] rd, ea, exp_rd;
        logic        ae;
        int          n, bad;

        tbl[0]  = '{1, 0, 32'h10, 3'd2, 32'h8899AABB, 0, 32'h0, 0, 32'h0};
        tbl[1]  = '{0, 1, 32'h13, 3'd0, 32'h0, 0, 32'hFFFFFF88, 0, 32'h0};
        tbl[2]  = '{0, 1, 32'h13, 3'd4, 32'h0, 0, 32'h00000088, 0, 32'h0};
        tbl[3]  = '{0, 1, 32'h10, 3'd1, 32'h0, 0, 32'hFFFFAABB, 0, 32'h0};
        tbl[4]  = '{0, 1, 32'h12, 3'd5, 32'h0, 0, 32'h00008899, 0, 32'h0};
        tbl[5]  = '{1, 0, 32'h20, 3'd2, 32'h11223344, 0, 32'h0, 0, 32'h0};
        tbl[6]  = '{1, 0, 32'h21, 3'd0, 32'hFFFFFF55, 0, 32'h0, 0, 32'h0};
        tbl[7]  = '{0, 1, 32'h20, 3'd2, 32'h0, 0, 32'h11225544, 0, 32'h0};
        tbl[8]  = '{1, 0, 32'h22, 3'd1, 32'h1234BEEF, 0, 32'h0, 0, 32'h0};
        tbl[9]  = '{0, 1, 32'h20, 3'd2, 32'h0, 0, 32'hBEEF5544, 0, 32'h0};
        tbl[10] = '{0, 1, 32'h10000010, 3'd2, 32'h0, 0, 32'h8899AABB, 0, 32'h0};
        tbl[11] = '{0, 0, 32'h10, 3'd2, 32'h0, 0, 32'h0, 0, 32'h0};
        tbl[12] = '{1, 0, 32'h31, 3'd2, 32'hDEADBEEF, 0, 32'h0, 1, 32'h31};
        tbl[13] = '{0, 1, 32'h30, 3'd2, 32'h0, 0, 32'h0, 1, 32'h31};
        tbl[14] = '{0, 1, 32'h45, 3'd1, 32'h0, 1, 32'h0, 1, 32'h45};
        tbl[15] = '{0, 0, 32'h0, 3'd0, 32'h0, 1, 32'h0, 0, 32'h45};
        tbl[16] = '{1, 1, 32'h8, 3'd2, 32'hCAFEF00D, 0, 32'h0, 0, 32'h45};
        tbl[17] = '{0, 1, 32'h8, 3'd2, 32'h0, 0, 32'hCAFEF00D, 0, 32'h45};
        tbl[18] = '{0, 1, 32'h8, 3'd7, 32'h0, 0, 32'h0, 1, 32'h8};
        tbl[19] = '{1, 0, 32'h4, 3'd4, 32'h000000AA, 0, 32'h0, 1, 32'h4};
        tbl[20] = '{0, 1, 32'h4, 3'd2, 32'h0, 0, 32'h0, 1, 32'h4};
        tbl[21] = '{0, 1, 32'h36, 3'd5, 32'h0, 1, 32'h0, 0, 32'h4};

        // Reset and clear length
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset acc_err", {31'h0, acc_err}, 32'h0);
        chk("reset err_addr", err_addr, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        count_busy(n, bad);
        chk("busy length", n, DEPTH);
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            access(0, 1, 32'(i * 4), 3'd2, 0, 0, rd, ae, ea, exp_rd);
            chk("cleared word", rd, 32'h0);
        end

        // Directed table
        for (int i = 0; i < 22; i++) begin
            access(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].t, tbl[i].d, tbl[i].c, rd, ae, ea, exp_rd);
            chk($sformatf("vec%0d rd", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d acc_err", i), {31'h0, ae}, {31'h0, tbl[i].ae});
            chk($sformatf("vec%0d err_addr", i), ea, tbl[i].ea);
        end

        // Reset mid-clear with erroring requests held during busy
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        W_en = 1; R_en = 1; ram_addr = 32'h31; RW_type = 3'd2; Wr_mem_data = 32'h12345678;
        repeat (7) @(negedge clk);
        chk("busy at cycle 7", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(n, bad);
        chk("busy restart length", n, DEPTH);
        chk("rd zero while busy", bad, 0);
        chk("no error while busy", {31'h0, acc_err}, 32'h0);
        idle_inputs();
        model_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [2:0]  t;
            logic        w, r;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'h3F;
            if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
            t = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            access(w, r, a, t, $urandom, ($urandom_range(0, 7) == 0), rd, ae, ea, exp_rd);
            chk($sformatf("rand%0d rd", i), rd, exp_rd);
            chk($sformatf("rand%0d acc_err", i), {31'h0, ae}, {31'h0, m_acc});
            chk($sformatf("rand%0d err_addr", i), ea, m_ea);
        end
        for (int i = 0; i < DEPTH; i++) begin
            access(0, 1, 32'(i * 4), 3'd2, 0, 0, rd, ae, ea, exp_rd);
            chk("final word", rd, m_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
